node_inject_queue: RTL and testbench



---
 rtl/router_pkg.sv | 17 +
 rtl/inject_fifo_mem.sv | 21 ++
 rtl/node_inject_queue.sv | 124 ++++++++++++
 tb/tb_node_inject_queue.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared router constants: packet geometry, field offsets and the inject-queue state encoding.
package router_pkg;
   localparam int ADDR_W = 4;
   localparam int DATA_W = 24;
   localparam int PKT_W  = ADDR_W + 1 + DATA_W;

   localparam int DEST_MSB = PKT_W - 1;
   localparam int DEST_LSB = DATA_W + 1;
   localparam int TYPE_BIT = DATA_W;
   localparam int DATA_MSB = DATA_W - 1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PRESENT = 2'd1,
      GAP     = 2'd2
   } q_state_e;
endpackage

// File: rtl/inject_fifo_mem.sv
// Packet storage for the injection queue: one synchronous write port, pointer-addressed async read.
module inject_fifo_mem #(
   parameter int DEPTH = 4,
   parameter int PKT_W = 29
) (
   input  logic                     clk,
   input  logic                     wr_en,
   input  logic [$clog2(DEPTH)-1:0] wr_ptr,
   input  logic [PKT_W-1:0]         wr_data,
   input  logic [$clog2(DEPTH)-1:0] rd_ptr,
   output logic [PKT_W-1:0]         rd_data
);
   logic [PKT_W-1:0] mem_q [DEPTH];

   // Payload storage carries no reset; occupancy lives in the controller's count.
   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_ptr] <= wr_data;
   end

   assign rd_data = mem_q[rd_ptr];
endmodule

// File: rtl/node_inject_queue.sv
// Node-to-router injection FIFO with a present/ack/gap handshake toward router_core.
// Optional build macro NODE_INJECT_SELF_FILTER_EN drops writes addressed to this router (r_addr).
module node_inject_queue #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = router_pkg::ADDR_W,
   parameter int DATA_W = router_pkg::DATA_W
) (
   input  logic                     Clk_R,
   input  logic                     Rst_n,
   input  logic                     Node_Wr_En,
   input  logic [ADDR_W-1:0]        Node_Dest,
   input  logic                     Node_Type,
   input  logic [DATA_W-1:0]        Node_Data,
   output logic                     Node_Full,
   output logic                     Node_Overflow,
   input  logic                     Core_Load_Ack,
   output logic [ADDR_W+DATA_W:0]   Packet_From_Node,
   output logic                     Packet_From_Node_Valid,
   output logic [$clog2(DEPTH):0]   Queue_Count
`ifdef NODE_INJECT_SELF_FILTER_EN
   ,
   input  logic [ADDR_W-1:0]        r_addr,
   output logic                     Self_Drop
`endif
);
   import router_pkg::*;

   localparam int PKT_BITS = ADDR_W + 1 + DATA_W;
   localparam int PTR_W    = $clog2(DEPTH);
   localparam int CNT_W    = PTR_W + 1;

   q_state_e            state_q, state_d;
   logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]    count_q, count_d;
   logic [PKT_BITS-1:0] pkt_q, pkt_d, head_pkt;
   logic                vld_q, vld_d, full_q, full_d, ovf_q, ovf_d;
   logic                self_hit, wr_ok, pop;

`ifdef NODE_INJECT_SELF_FILTER_EN
   logic self_drop_q, self_drop_d;
   assign self_hit  = Node_Wr_En && (Node_Dest == r_addr);
   assign Self_Drop = self_drop_q;
`else
   assign self_hit = 1'b0;
`endif

   inject_fifo_mem #(.DEPTH(DEPTH), .PKT_W(PKT_BITS)) u_mem (
      .clk     (Clk_R),
      .wr_en   (wr_ok),
      .wr_ptr  (wr_ptr_q),
      .wr_data ({Node_Dest, Node_Type, Node_Data}),
      .rd_ptr  (rd_ptr_q),
      .rd_data (head_pkt)
   );

   always_comb begin
      // Fullness is judged on the registered count, so a same-edge pop cannot admit a write.
      wr_ok    = Node_Wr_En && !self_hit && !full_q;
      pop      = (state_q == PRESENT) && Core_Load_Ack;
      wr_ptr_d = wr_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      count_d  = count_q + CNT_W'(wr_ok) - CNT_W'(pop);
      full_d   = (count_d == CNT_W'(DEPTH));
      ovf_d    = ovf_q | (Node_Wr_En && !self_hit && full_q);
`ifdef NODE_INJECT_SELF_FILTER_EN
      self_drop_d = self_hit;
`endif

      state_d = state_q;
      vld_d   = vld_q;
      pkt_d   = pkt_q;
      case (state_q)
         IDLE: begin
            if (count_q != '0) begin
               pkt_d   = head_pkt;
               vld_d   = 1'b1;
               state_d = PRESENT;
            end
         end
         PRESENT: begin
            if (Core_Load_Ack) begin
               vld_d   = 1'b0;
               state_d = GAP;
            end
         end
         GAP:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clk_R or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q  <= IDLE;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         pkt_q    <= '0;
         vld_q    <= 1'b0;
         full_q   <= 1'b0;
         ovf_q    <= 1'b0;
`ifdef NODE_INJECT_SELF_FILTER_EN
         self_drop_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         pkt_q    <= pkt_d;
         vld_q    <= vld_d;
         full_q   <= full_d;
         ovf_q    <= ovf_d;
`ifdef NODE_INJECT_SELF_FILTER_EN
         self_drop_q <= self_drop_d;
`endif
      end
   end

   assign Node_Full              = full_q;
   assign Node_Overflow          = ovf_q;
   assign Packet_From_Node       = pkt_q;
   assign Packet_From_Node_Valid = vld_q;
   assign Queue_Count            = count_q;
endmodule

// File: tb/tb_node_inject_queue.sv
// Directed bench for node_inject_queue: queue-level reference model plus literal spot checks.
module tb_node_inject_queue;
   localparam int DEPTH  = 4;
   localparam int ADDR_W = 4;
   localparam int DATA_W = 24;
   localparam int PKT_W  = ADDR_W + 1 + DATA_W;

   logic              Clk_R, Rst_n;
   logic              Node_Wr_En, Node_Type, Core_Load_Ack;
   logic [ADDR_W-1:0] Node_Dest;
   logic [DATA_W-1:0] Node_Data;
   logic              Node_Full, Node_Overflow, Packet_From_Node_Valid;
   logic [PKT_W-1:0]  Packet_From_Node;
   logic [$clog2(DEPTH):0] Queue_Count;
   logic [ADDR_W-1:0] r_addr;
   logic              Self_Drop;

   int n_checks = 0;
   int n_fail   = 0;

   node_inject_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .Clk_R                  (Clk_R),
      .Rst_n                  (Rst_n),
      .Node_Wr_En             (Node_Wr_En),
      .Node_Dest              (Node_Dest),
      .Node_Type              (Node_Type),
      .Node_Data              (Node_Data),
      .Node_Full              (Node_Full),
      .Node_Overflow          (Node_Overflow),
      .Core_Load_Ack          (Core_Load_Ack),
      .Packet_From_Node       (Packet_From_Node),
      .Packet_From_Node_Valid (Packet_From_Node_Valid),
      .Queue_Count            (Queue_Count)
`ifdef NODE_INJECT_SELF_FILTER_EN
      ,
      .r_addr                 (r_addr),
      .Self_Drop              (Self_Drop)
`endif
   );

`ifndef NODE_INJECT_SELF_FILTER_EN
   assign Self_Drop = 1'b0;
`endif

   initial begin
      Clk_R = 1'b0;
      forever #5 Clk_R = ~Clk_R;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a packet queue, a "presenting" flag and a post-ack hold-off.
   logic [PKT_W-1:0] m_q[$];
   bit   m_pres, m_ovf, m_self;
   int   m_cool, m_sz0;

   always @(posedge Clk_R or negedge Rst_n) begin
      if (!Rst_n) begin
         m_q.delete();
         m_pres = 0; m_ovf = 0; m_self = 0; m_cool = 0;
      end else begin
         m_sz0  = m_q.size();
`ifdef NODE_INJECT_SELF_FILTER_EN
         m_self = Node_Wr_En && (Node_Dest == r_addr);
`else
         m_self = 0;
`endif
         if (m_pres && Core_Load_Ack) begin
            void'(m_q.pop_front());
            m_pres = 0;
            m_cool = 1;
         end else if (!m_pres) begin
            if (m_cool > 0) m_cool--;
            else if (m_sz0 > 0) m_pres = 1;
         end
         if (Node_Wr_En && !m_self) begin
            if (m_sz0 < DEPTH) m_q.push_back({Node_Dest, Node_Type, Node_Data});
            else m_ovf = 1;
         end
      end
   end

   always @(negedge Clk_R) begin
      if (Rst_n) begin
         check("valid", Packet_From_Node_Valid, m_pres);
         check("count", Queue_Count, m_q.size());
         check("full", Node_Full, m_q.size() == DEPTH);
         check("overflow", Node_Overflow, m_ovf);
         check("self_drop", Self_Drop, m_self);
         if (m_pres) check("packet", Packet_From_Node, m_q[0]);
      end
   end

   task automatic wr(input logic [3:0] dest, input logic typ, input logic [23:0] data);
      Node_Wr_En = 1'b1; Node_Dest = dest; Node_Type = typ; Node_Data = data;
      @(negedge Clk_R);
      Node_Wr_En = 1'b0;
   endtask

   task automatic wait_valid();
      int i;
      for (i = 0; i < 100 && !Packet_From_Node_Valid; i++) @(negedge Clk_R);
      if (!Packet_From_Node_Valid) check("wait_valid_timeout", 0, 1);
   endtask

   task automatic ack_expect(input logic [23:0] data);
      wait_valid();
      check("deliver_data", Packet_From_Node[23:0], data);
      Core_Load_Ack = 1'b1;
      @(negedge Clk_R);
      Core_Load_Ack = 1'b0;
      check("valid_drop_after_ack", Packet_From_Node_Valid, 0);
   endtask

   initial begin
      Rst_n = 1'b0; Node_Wr_En = 1'b0; Node_Dest = '0; Node_Type = 1'b0;
      Node_Data = '0; Core_Load_Ack = 1'b0; r_addr = 4'b0010;
      repeat (3) @(negedge Clk_R);
      check("rst_valid", Packet_From_Node_Valid, 0);
      check("rst_count", Queue_Count, 0);
      check("rst_full", Node_Full, 0);
      check("rst_ovf", Node_Overflow, 0);
      check("rst_packet", Packet_From_Node, 0);
      Rst_n = 1'b1;
      @(negedge Clk_R);

      // Single packet: valid one edge after the write edge.
      wr(4'b0001, 1'b0, 24'd42);
      check("t1_count_after_wr", Queue_Count, 1);
      check("t1_valid_not_yet", Packet_From_Node_Valid, 0);
      @(negedge Clk_R);
      check("t1_valid", Packet_From_Node_Valid, 1);
      check("t1_packet", Packet_From_Node, 29'h0200002A);
      repeat (49) @(negedge Clk_R);
      check("t1_hold_valid", Packet_From_Node_Valid, 1);
      check("t1_hold_packet", Packet_From_Node, 29'h0200002A);
      check("t1_hold_count", Queue_Count, 1);
      Core_Load_Ack = 1'b1;
      @(negedge Clk_R);
      Core_Load_Ack = 1'b0;
      check("t1_gap_valid", Packet_From_Node_Valid, 0);
      check("t1_gap_count", Queue_Count, 0);
      repeat (3) @(negedge Clk_R);
      check("t1_empty_valid", Packet_From_Node_Valid, 0);

      // Fill to DEPTH, then overflow.
      for (int i = 1; i <= 4; i++) wr(4'b0011, 1'b1, 24'(i));
      check("t2_full", Node_Full, 1);
      check("t2_count4", Queue_Count, 4);
      wr(4'b0011, 1'b1, 24'd5);
      check("t2_overflow", Node_Overflow, 1);
      check("t2_count_still4", Queue_Count, 4);
      for (int i = 1; i <= 4; i++) ack_expect(24'(i));

      // Write coinciding with ack at count 2; order across wrap.
      wr(4'b0101, 1'b0, 24'd6);
      wr(4'b0101, 1'b0, 24'd7);
      wait_valid();
      check("t3_count2", Queue_Count, 2);
      check("t3_head6", Packet_From_Node[23:0], 24'd6);
      Core_Load_Ack = 1'b1;
      wr(4'b0101, 1'b0, 24'd8);
      Core_Load_Ack = 1'b0;
      check("t3_count_kept2", Queue_Count, 2);
      ack_expect(24'd7);
      ack_expect(24'd8);

      // Asynchronous reset while presenting with three queued.
      wr(4'b0011, 1'b0, 24'd9);
      wr(4'b0011, 1'b0, 24'd10);
      wr(4'b0011, 1'b0, 24'd11);
      wait_valid();
      check("t4_count3", Queue_Count, 3);
      #3 Rst_n = 1'b0;
      #1;
      check("t4_async_valid", Packet_From_Node_Valid, 0);
      check("t4_async_count", Queue_Count, 0);
      check("t4_async_full", Node_Full, 0);
      check("t4_async_ovf", Node_Overflow, 0);
      check("t4_async_packet", Packet_From_Node, 0);
      @(negedge Clk_R);
      Rst_n = 1'b1;
      @(negedge Clk_R);
      wr(4'b0000, 1'b0, 24'd100);
      ack_expect(24'd100);
      repeat (3) @(negedge Clk_R);

`ifdef NODE_INJECT_SELF_FILTER_EN
      wr(4'b0010, 1'b0, 24'd55);
      check("t5_self_drop", Self_Drop, 1);
      check("t5_count_unchanged", Queue_Count, 0);
      @(negedge Clk_R);
      check("t5_self_drop_pulse", Self_Drop, 0);
      wr(4'b0000, 1'b0, 24'd56);
      check("t5_queued", Queue_Count, 1);
      ack_expect(24'd56);
      repeat (3) @(negedge Clk_R);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1, "watchdog expired");
   end
endmodule
